// File: rtl/pq_pkg.sv
// Shared types for the priority-queue cell array and its head-end controller.
// Contents: opcode and error enums, and the cell_t {id, data} payload
// exchanged with cell 0. cell_t widths are fixed here; controllers that
// change TW/IW must keep them equal to PQ_TW/PQ_IW.
package pq_pkg;

  localparam int unsigned PQ_TW = 16;
  localparam int unsigned PQ_IW = 4;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_DROP = 2'b10,
    OP_RSVD = 2'b11
  } pq_op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_FULL    = 2'b01,
    ERR_EMPTY   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } pq_err_e;

  typedef struct packed {
    logic [PQ_IW-1:0] id;
    logic [PQ_TW-1:0] data;
  } cell_t;

endpackage

// File: rtl/pq_ctrl_fsm.sv
// Control FSM for pq_ctrl: IDLE -> ISSUE -> RESP sequencing, operation
// strobes to cell 0, request-ready / response-valid decode, and the optional
// ISSUE timeout counter (enabled by defining PQ_CTRL_TIMEOUT_EN).
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   req_valid_i/req_ready_o client request handshake
//   req_op_i, req_data_zero_i, full_i  inputs to the immediate-error check
//   *_vld_i                cell 0 acknowledges
//   rsp_ready_i/rsp_valid_o client response handshake
//   accept_o, issue_o      request accepted / accepted and sent to the array
//   imm_err_o              immediate error code for the accepted request
//   xfer_o, timeout_o      ISSUE ends by transfer / by timeout this cycle
//   push_o, pop_o, drop_o  registered strobes to cell 0
module pq_ctrl_fsm
  import pq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    req_valid_i,
  output logic    req_ready_o,
  input  pq_op_e  req_op_i,
  input  logic    req_data_zero_i,
  input  logic    full_i,
  input  logic    push_vld_i,
  input  logic    pop_vld_i,
  input  logic    drop_vld_i,
  input  logic    rsp_ready_i,
  output logic    accept_o,
  output logic    issue_o,
  output pq_err_e imm_err_o,
  output logic    xfer_o,
  output logic    timeout_o,
  output logic    push_o,
  output logic    pop_o,
  output logic    drop_o,
  output logic    rsp_valid_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] strobe_q, strobe_d;  // {drop, pop, push}
  logic       rsp_valid_q, rsp_valid_d;
  logic       timeout_hit;

  assign push_o      = strobe_q[0];
  assign pop_o       = strobe_q[1];
  assign drop_o      = strobe_q[2];
  assign rsp_valid_o = rsp_valid_q;
  assign req_ready_o = (state_q == S_IDLE);

  // Transfer: the acknowledge matches the strobe currently held high.
  assign xfer_o = (strobe_q[0] & push_vld_i) | (strobe_q[1] & pop_vld_i) |
                  (strobe_q[2] & drop_vld_i);
  assign timeout_o = timeout_hit;

  // Requests that never reach the array; empty/illegal outranks full.
  always_comb begin
    imm_err_o = ERR_OK;
    if (req_op_i == OP_RSVD || (req_op_i == OP_PUSH && req_data_zero_i)) begin
      imm_err_o = ERR_EMPTY;
    end else if (req_op_i == OP_PUSH && full_i) begin
      imm_err_o = ERR_FULL;
    end
  end

`ifdef PQ_CTRL_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  // cnt_q counts ISSUE cycles already spent without a transfer.
  assign timeout_hit = (state_q == S_ISSUE) && !xfer_o && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (issue_o) begin
      cnt_q <= '0;
    end else if (state_q == S_ISSUE && !xfer_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state and strobe logic.
  always_comb begin
    state_d  = state_q;
    strobe_d = strobe_q;
    accept_o = 1'b0;
    issue_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          accept_o = 1'b1;
          if (imm_err_o != ERR_OK) begin
            state_d = S_RESP;
          end else begin
            issue_o = 1'b1;
            state_d = S_ISSUE;
            case (req_op_i)
              OP_PUSH: strobe_d = 3'b001;
              OP_POP:  strobe_d = 3'b010;
              default: strobe_d = 3'b100;
            endcase
          end
        end
      end
      S_ISSUE: begin
        if (xfer_o || timeout_hit) begin
          strobe_d = 3'b000;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: begin
        strobe_d = 3'b000;
        state_d  = S_IDLE;
      end
    endcase
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      strobe_q    <= 3'b000;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      strobe_q    <= strobe_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: rtl/pq_ctrl.sv
// Head-end initiator for the systolic priority-queue cell array. Takes one
// push/pop/drop request at a time, drives cell 0's strobes, waits for the
// acknowledge, and returns exactly one response per request.
// Optional feature: define PQ_CTRL_TIMEOUT_EN to abort ISSUE after TIMEOUT
// cycles with err 11; by default ISSUE waits indefinitely.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   req_*                          client request (valid/ready, op, data, id)
//   rsp_*                          client response (valid/ready, op, data, id, err)
//   full_i                         array-full from tail cell (sampled in IDLE)
//   push_o/pop_o/drop_o, drop_id_o, push_struct_o  requests to cell 0
//   push_vld_i/pop_vld_i/drop_vld_i, pop_struct_i  cell 0 acknowledges / pop data
module pq_ctrl
  import pq_pkg::*;
#(
  parameter int unsigned TW      = PQ_TW,
  parameter int unsigned IW      = PQ_IW,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [TW-1:0] req_data_i,
  input  logic [IW-1:0] req_id_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [1:0]    rsp_op_o,
  output logic [TW-1:0] rsp_data_o,
  output logic [IW-1:0] rsp_id_o,
  output logic [1:0]    rsp_err_o,
  input  logic          full_i,
  output logic          push_o,
  output logic          pop_o,
  output logic          drop_o,
  output logic [TW-1:0] drop_id_o,
  input  logic          push_vld_i,
  input  logic          pop_vld_i,
  input  logic          drop_vld_i,
  output cell_t         push_struct_o,
  input  cell_t         pop_struct_i
);

  pq_op_e        req_op;
  pq_op_e        op_q;
  logic [IW-1:0] id_q;
  logic          accept, issue, xfer, timeout;
  pq_err_e       imm_err;
  pq_op_e        rsp_op_q;
  logic [TW-1:0] rsp_data_q;
  logic [IW-1:0] rsp_id_q;
  pq_err_e       rsp_err_q;
  cell_t         push_struct_q;
  logic [TW-1:0] drop_id_q;

  assign req_op        = pq_op_e'(req_op_i);
  assign rsp_op_o      = rsp_op_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_err_o     = rsp_err_q;
  assign push_struct_o = push_struct_q;
  assign drop_id_o     = drop_id_q;

  pq_ctrl_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op),
    .req_data_zero_i(req_data_i == '0),
    .full_i         (full_i),
    .push_vld_i     (push_vld_i),
    .pop_vld_i      (pop_vld_i),
    .drop_vld_i     (drop_vld_i),
    .rsp_ready_i    (rsp_ready_i),
    .accept_o       (accept),
    .issue_o        (issue),
    .imm_err_o      (imm_err),
    .xfer_o         (xfer),
    .timeout_o      (timeout),
    .push_o         (push_o),
    .pop_o          (pop_o),
    .drop_o         (drop_o),
    .rsp_valid_o    (rsp_valid_o)
  );

  // Request latch, array payload and response latch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q          <= OP_PUSH;
      id_q          <= '0;
      push_struct_q <= '0;
      drop_id_q     <= '0;
      rsp_op_q      <= OP_PUSH;
      rsp_data_q    <= '0;
      rsp_id_q      <= '0;
      rsp_err_q     <= ERR_OK;
    end else begin
      if (accept) begin
        op_q <= req_op;
        id_q <= req_id_i;
        if (issue && req_op == OP_PUSH) begin
          push_struct_q <= '{id: PQ_IW'(req_id_i), data: PQ_TW'(req_data_i)};
        end
        if (issue && req_op == OP_DROP) drop_id_q <= TW'(req_id_i);
        // Immediate errors respond straight from the request fields.
        if (imm_err != ERR_OK) begin
          rsp_op_q   <= req_op;
          rsp_data_q <= '0;
          rsp_id_q   <= req_id_i;
          rsp_err_q  <= imm_err;
        end
      end
      if (xfer) begin
        rsp_op_q <= op_q;
        if (op_q == OP_POP) begin
          // A zero priority from cell 0 means the array was empty.
          rsp_data_q <= TW'(pop_struct_i.data);
          rsp_id_q   <= IW'(pop_struct_i.id);
          rsp_err_q  <= (pop_struct_i.data == '0) ? ERR_EMPTY : ERR_OK;
        end else begin
          rsp_data_q <= '0;
          rsp_id_q   <= id_q;
          rsp_err_q  <= ERR_OK;
        end
      end
      if (timeout) begin
        rsp_op_q   <= op_q;
        rsp_data_q <= '0;
        rsp_id_q   <= id_q;
        rsp_err_q  <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_pq_ctrl.sv
// Directed self-checking bench for pq_ctrl: push, stalled pop, empty pop,
// immediate errors, drop with response backpressure, reset mid-ISSUE, and
// the ISSUE timeout when PQ_CTRL_TIMEOUT_EN is defined.
module tb_pq_ctrl;
  import pq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [15:0] req_data_i;
  logic [3:0]  req_id_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_op_o;
  logic [15:0] rsp_data_o;
  logic [3:0]  rsp_id_o;
  logic [1:0]  rsp_err_o;
  logic        full_i;
  logic        push_o, pop_o, drop_o;
  logic [15:0] drop_id_o;
  logic        push_vld_i, pop_vld_i, drop_vld_i;
  cell_t       push_struct_o;
  cell_t       pop_struct_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  pq_ctrl #(.TW(16), .IW(4), .TIMEOUT(64)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_data_i   (req_data_i),
    .req_id_i     (req_id_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_op_o     (rsp_op_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_err_o    (rsp_err_o),
    .full_i       (full_i),
    .push_o       (push_o),
    .pop_o        (pop_o),
    .drop_o       (drop_o),
    .drop_id_o    (drop_id_o),
    .push_vld_i   (push_vld_i),
    .pop_vld_i    (pop_vld_i),
    .drop_vld_i   (drop_vld_i),
    .push_struct_o(push_struct_o),
    .pop_struct_i (pop_struct_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request for a single accept edge; returns in cycle 1.
  task automatic send(input logic [1:0] op, input logic [15:0] data, input logic [3:0] id);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_data_i  = data;
    req_id_i    = id;
    tick();
    req_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_op_i     = 2'b00;
    req_data_i   = '0;
    req_id_i     = '0;
    rsp_ready_i  = 1'b1;
    full_i       = 1'b0;
    push_vld_i   = 1'b0;
    pop_vld_i    = 1'b0;
    drop_vld_i   = 1'b0;
    pop_struct_i = '0;
    #3;
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_strobes", 32'({push_o, pop_o, drop_o}), 32'd0);
    check("rst_payload", 32'({drop_id_o, push_struct_o}), 32'd0);
    check("rst_rsp_fields", 32'({rsp_op_o, rsp_data_o, rsp_id_o, rsp_err_o}), 32'd0);
    #9 rst_ni = 1'b1;
    tick();

    // Push data=5 id=2, acknowledge already high.
    push_vld_i = 1'b1;
    send(2'b00, 16'd5, 4'd2);
    check("push_strobe_c1", 32'(push_o), 32'd1);
    check("push_struct_c1", 32'(push_struct_o), 32'h20005);
    check("push_ready_c1", 32'(req_ready_o), 32'd0);
    check("push_rspv_c1", 32'(rsp_valid_o), 32'd0);
    tick();
    check("push_strobe_c2", 32'(push_o), 32'd0);
    check("push_rspv_c2", 32'(rsp_valid_o), 32'd1);
    check("push_err", 32'(rsp_err_o), 32'd0);
    check("push_op", 32'(rsp_op_o), 32'd0);
    tick();
    check("push_done_rspv", 32'(rsp_valid_o), 32'd0);
    check("push_done_ready", 32'(req_ready_o), 32'd1);
    push_vld_i = 1'b0;

    // Pop stalled 4 cycles, then acknowledged with {3,7}.
    send(2'b01, 16'd0, 4'd0);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("pop_stall_c%0d", c), 32'({push_o, pop_o, drop_o, rsp_valid_o}), 32'b0100);
      tick();
    end
    pop_vld_i    = 1'b1;
    pop_struct_i = '{id: 4'd3, data: 16'd7};
    check("pop_strobe_c5", 32'(pop_o), 32'd1);
    tick();
    check("pop_strobe_off", 32'(pop_o), 32'd0);
    check("pop_rspv", 32'(rsp_valid_o), 32'd1);
    check("pop_data", 32'(rsp_data_o), 32'd7);
    check("pop_id", 32'(rsp_id_o), 32'd3);
    check("pop_err", 32'(rsp_err_o), 32'd0);
    check("pop_op", 32'(rsp_op_o), 32'd1);
    tick();

    // Pop from an empty array.
    pop_struct_i = '{id: 4'd0, data: 16'd0};
    send(2'b01, 16'd0, 4'd0);
    check("epop_strobe", 32'(pop_o), 32'd1);
    tick();
    check("epop_rspv", 32'(rsp_valid_o), 32'd1);
    check("epop_err", 32'(rsp_err_o), 32'd2);
    check("epop_data", 32'(rsp_data_o), 32'd0);
    tick();
    pop_vld_i = 1'b0;

    // Push while full.
    full_i = 1'b1;
    send(2'b00, 16'd5, 4'd1);
    check("full_strobe", 32'(push_o), 32'd0);
    check("full_rspv_c1", 32'(rsp_valid_o), 32'd1);
    check("full_err", 32'(rsp_err_o), 32'd1);
    check("full_id", 32'(rsp_id_o), 32'd1);
    tick();
    full_i = 1'b0;

    // Push with reserved priority 0.
    send(2'b00, 16'd0, 4'd6);
    check("zero_strobe", 32'(push_o), 32'd0);
    check("zero_rspv_c1", 32'(rsp_valid_o), 32'd1);
    check("zero_err", 32'(rsp_err_o), 32'd2);
    check("zero_id", 32'(rsp_id_o), 32'd6);
    tick();

    // Reserved opcode.
    send(2'b11, 16'd4, 4'd5);
    check("rsvd_strobes", 32'({push_o, pop_o, drop_o}), 32'd0);
    check("rsvd_err", 32'(rsp_err_o), 32'd2);
    check("rsvd_op", 32'(rsp_op_o), 32'd3);
    tick();

    // Drop id=9 with late acknowledge and response backpressure.
    rsp_ready_i = 1'b0;
    send(2'b10, 16'd0, 4'd9);
    check("drop_strobe_c1", 32'(drop_o), 32'd1);
    check("drop_id_c1", 32'(drop_id_o), 32'h0009);
    tick();
    check("drop_strobe_c2", 32'(drop_o), 32'd1);
    check("drop_id_c2", 32'(drop_id_o), 32'h0009);
    drop_vld_i = 1'b1;
    tick();
    drop_vld_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("drop_hold%0d", c),
            32'({rsp_valid_o, req_ready_o, drop_o, rsp_op_o, rsp_err_o, rsp_id_o}),
            32'({1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 4'd9}));
      tick();
    end
    rsp_ready_i = 1'b1;
    check("drop_rspv_last", 32'(rsp_valid_o), 32'd1);
    tick();
    check("drop_done", 32'({rsp_valid_o, req_ready_o}), 32'b01);

    // Reset in the middle of ISSUE.
    send(2'b01, 16'd0, 4'd0);
    check("rstmid_strobe", 32'(pop_o), 32'd1);
    tick();
    rst_ni = 1'b0;
    #1;
    check("rstmid_strobes", 32'({push_o, pop_o, drop_o}), 32'd0);
    check("rstmid_idle", 32'({req_ready_o, rsp_valid_o}), 32'b10);
    #2 rst_ni = 1'b1;
    pop_vld_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rstmid_quiet%0d", c), 32'({pop_o, rsp_valid_o, req_ready_o}), 32'b001);
    end
    pop_vld_i = 1'b0;

`ifdef PQ_CTRL_TIMEOUT_EN
    // Pop never acknowledged: strobe lasts exactly TIMEOUT cycles.
    send(2'b01, 16'd0, 4'd4);
    n = 0;
    while (pop_o && n < 200) begin
      n++;
      tick();
    end
    check("tmo_cycles", 32'(n), 32'd64);
    check("tmo_rspv", 32'(rsp_valid_o), 32'd1);
    check("tmo_err", 32'(rsp_err_o), 32'd3);
    check("tmo_id", 32'(rsp_id_o), 32'd4);
    tick();
    check("tmo_done", 32'(req_ready_o), 32'd1);
`else
    n = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
